// File: rtl/bf16_ctrl_pkg.sv
// Shared types and helpers for the bf16 argmax/argmin controller.
//   state_e      : controller FSM states
//   BF16_EXP_MAX : all-ones bf16 exponent (inf / NaN)
//   is_nan()     : true for exponent all-ones with a nonzero fraction
package bf16_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] BF16_EXP_MAX = 8'hFF;

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:7] == BF16_EXP_MAX) && (x[6:0] != 7'd0);
    endfunction

endpackage

// File: rtl/bf16_cmp.sv
// Combinational bf16 comparator over ordered (non-NaN) operands.
//   a_i, b_i           : bf16 operands
//   doEq_i/doLt_i/doLe_i : select which relations assert res_o
//   res_o              : OR of the selected relations; 0 when either side is NaN
// +0 and -0 compare equal.
module bf16_cmp
    import bf16_ctrl_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        doEq_i,
    input  logic        doLt_i,
    input  logic        doLe_i,
    output logic        res_o
);

    logic unordered;
    logic both_zero;
    logic eq;
    logic lt;

    always_comb begin
        unordered = is_nan(a_i) || is_nan(b_i);
        both_zero = (a_i[14:0] == 15'd0) && (b_i[14:0] == 15'd0);
        eq        = both_zero || (a_i == b_i);
        if (a_i[15] != b_i[15]) begin
            // Differing signs: the negative side is smaller unless both are zero.
            lt = a_i[15] && !both_zero;
        end else if (!a_i[15]) begin
            lt = a_i[14:0] < b_i[14:0];
        end else begin
            // Both negative: larger magnitude is the smaller value.
            lt = a_i[14:0] > b_i[14:0];
        end
        res_o = !unordered && ((doEq_i && eq) || (doLt_i && lt) || (doLe_i && (lt || eq)));
    end

endmodule

// File: rtl/bf16_argmax_ctrl.sv
// Streaming bf16 argmax/argmin reduction controller.
//   clk_i, rst_ni             : clock, async active-low reset
//   start_i, mode_i, len_i    : kick off a reduction (mode 0 = argmax, 1 = argmin)
//   abort_i                   : cancel current operation, back to IDLE
//   in_valid_i/in_ready_o, in_data_i : element stream
//   res_valid_o/res_ready_i, res_val_o, res_idx_o, res_nan_o : result
//   busy_o                    : not IDLE
module bf16_argmax_ctrl
    import bf16_ctrl_pkg::*;
#(
    parameter int MAX_LEN = 256,
    localparam int CNT_W  = $clog2(MAX_LEN) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             abort_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      in_data_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [15:0]      res_val_o,
    output logic [CNT_W-1:0] res_idx_o,
    output logic             res_nan_o,
    output logic             busy_o
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      best_q, best_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             nan_q, nan_d;

    logic [15:0] op_a, op_b;
    logic        cmp_lt;
    logic        accept;
    logic        replace;

    // One shared comparator; argmax asks best < x, argmin asks x < best.
    assign op_a = mode_q ? in_data_i : best_q;
    assign op_b = mode_q ? best_q    : in_data_i;

    bf16_cmp u_cmp (
        .a_i    (op_a),
        .b_i    (op_b),
        .doEq_i (1'b0),
        .doLt_i (1'b1),
        .doLe_i (1'b0),
        .res_o  (cmp_lt)
    );

    // Pure state decodes: no path from in_valid_i / res_ready_i.
    assign in_ready_o  = (state_q == ST_RUN);
    assign res_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign res_val_o   = best_q;
    assign res_idx_o   = idx_q;
    assign res_nan_o   = nan_q;

    assign accept  = in_valid_i && in_ready_o;
    // A NaN incumbent yields to any ordered value; the comparator itself
    // never selects a NaN challenger.
    assign replace = (is_nan(best_q) && !is_nan(in_data_i)) || cmp_lt;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        best_d  = best_q;
        idx_d   = idx_q;
        nan_d   = nan_q;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_d  = mode_i;
                        len_d   = len_i;
                        cnt_d   = '0;
                        best_d  = 16'h0000;
                        idx_d   = '0;
                        nan_d   = 1'b0;
                        state_d = (len_i == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if ((cnt_q == '0) || replace) begin
                            best_d = in_data_i;
                            idx_d  = cnt_q;
                        end
                        if (is_nan(in_data_i)) nan_d = 1'b1;
                        if (cnt_q == len_q - CNT_W'(1)) state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            best_q  <= 16'h0000;
            idx_q   <= '0;
            nan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            best_q  <= best_d;
            idx_q   <= idx_d;
            nan_q   <= nan_d;
        end
    end

endmodule

// File: tb/tb_bf16_argmax_ctrl.sv
// Scoreboard bench for bf16_argmax_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_bf16_argmax_ctrl;

    localparam int MAXL  = 256;
    localparam int CNT_W = $clog2(MAXL) + 1;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             start_i, mode_i, abort_i, in_valid_i, res_ready_i;
    logic [CNT_W-1:0] len_i;
    logic [15:0]      in_data_i;
    logic             in_ready_o, res_valid_o, res_nan_o, busy_o;
    logic [15:0]      res_val_o;
    logic [CNT_W-1:0] res_idx_o;

    typedef struct {
        logic [15:0]      v;
        logic [CNT_W-1:0] idx;
        logic             nan;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    bf16_argmax_ctrl #(.MAX_LEN(MAXL)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .len_i       (len_i),
        .abort_i     (abort_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_val_o   (res_val_o),
        .res_idx_o   (res_idx_o),
        .res_nan_o   (res_nan_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_ni && res_valid_o && res_ready_i) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got val=%0h idx=%0d expected none",
                         res_val_o, res_idx_o);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("res_val", 32'(res_val_o), 32'(e.v));
                chk("res_idx", 32'(res_idx_o), 32'(e.idx));
                chk("res_nan", 32'(res_nan_o), 32'(e.nan));
            end
        end
    end

    function automatic real bf2r(input logic [15:0] b);
        int  e;
        real m;
        e = int'(b[14:7]);
        if (e == 0) m = (real'(b[6:0]) / 128.0) * (2.0 ** (-126));
        else        m = (1.0 + real'(b[6:0]) / 128.0) * (2.0 ** (e - 127));
        return b[15] ? -m : m;
    endfunction

    task automatic push(input logic [15:0] v, input int idx, input logic nan);
        exp_t e;
        e.v = v; e.idx = CNT_W'(idx); e.nan = nan;
        sbq.push_back(e);
    endtask

    // Issue a start, then stream n elements; checks 1-cycle result latency.
    task automatic run(input logic m, input int n, input logic [15:0] d[$], input bit gaps);
        start_i = 1'b1; mode_i = m; len_i = CNT_W'(n);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 2));
                for (int k = 0; k < g; k++) begin
                    in_valid_i = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid_i = 1'b1;
            in_data_i  = d[i];
            if (i == n - 1) chk("valid_before_last", 32'(res_valid_o), 32'd0);
            @(posedge clk); #1;
            in_valid_i = 1'b0;
        end
        chk("valid_latency", 32'(res_valid_o), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy_o; i++) begin
            @(posedge clk); #1;
        end
        chk("back_to_idle", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d[$];
        logic [15:0] bv;
        int          bi;

        rst_ni = 1'b0; start_i = 1'b0; mode_i = 1'b0; len_i = '0; abort_i = 1'b0;
        in_valid_i = 1'b0; in_data_i = '0; res_ready_i = 1'b1;
        #12;
        chk("rst_in_ready",  32'(in_ready_o),  32'd0);
        chk("rst_res_valid", 32'(res_valid_o), 32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);
        chk("rst_val",       32'(res_val_o),   32'd0);
        chk("rst_idx",       32'(res_idx_o),   32'd0);
        chk("rst_nan",       32'(res_nan_o),   32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Argmax basic
        d = '{16'h3F80, 16'h4040, 16'hC000, 16'h4000};
        push(16'h4040, 1, 1'b0);
        run(1'b0, 4, d, 1'b0);
        wait_idle();

        // Argmin, +0 vs -0 tie keeps first
        d = '{16'h0000, 16'h8000, 16'h3F80};
        push(16'h0000, 0, 1'b0);
        run(1'b1, 3, d, 1'b0);
        wait_idle();

        // NaN handling; inf is ordered
        d = '{16'h7FC1, 16'h3F80, 16'h7F80};
        push(16'h7F80, 2, 1'b1);
        run(1'b0, 3, d, 1'b0);
        wait_idle();
        d = '{16'h7FC1, 16'hFFC0};
        push(16'h7FC1, 0, 1'b1);
        run(1'b0, 2, d, 1'b0);
        wait_idle();

        // Backpressure on result, start ignored while DONE
        res_ready_i = 1'b0;
        d = '{16'h4000, 16'hBF80};
        push(16'hBF80, 1, 1'b0);
        run(1'b1, 2, d, 1'b0);
        for (int c = 0; c < 5; c++) begin
            start_i = c[0]; len_i = CNT_W'(3);
            @(posedge clk); #1;
            chk("hold_valid",    32'(res_valid_o), 32'd1);
            chk("hold_in_ready", 32'(in_ready_o),  32'd0);
            chk("hold_val",      32'(res_val_o),   32'hBF80);
            chk("hold_idx",      32'(res_idx_o),   32'd1);
        end
        start_i = 1'b1;
        res_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("no_restart_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        chk("idle_stays", 32'(busy_o), 32'd0);

        // Zero length
        d = {};
        push(16'h0000, 0, 1'b0);
        run(1'b0, 0, d, 1'b0);
        wait_idle();

        // Full length with input gaps, checked against a real-valued model
        d = {};
        for (int i = 0; i < MAXL; i++) begin
            logic [15:0] x;
            x = 16'($urandom);
            if (x[14:7] == 8'hFF) x[14] = 1'b0;
            if (i % 37 == 5) x = 16'h4300;   // repeated value exercises ties
            d.push_back(x);
        end
        bv = d[0]; bi = 0;
        for (int i = 1; i < MAXL; i++)
            if (bf2r(d[i]) > bf2r(bv)) begin bv = d[i]; bi = i; end
        push(bv, bi, 1'b0);
        run(1'b0, MAXL, d, 1'b1);
        wait_idle();

        // Abort mid-run: no result
        start_i = 1'b1; mode_i = 1'b0; len_i = CNT_W'(4);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1; in_data_i = 16'h3F80;
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0; abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 32'(res_valid_o), 32'd0);
        end

        // Reset mid-run, then a clean run
        start_i = 1'b1; mode_i = 1'b1; len_i = CNT_W'(4);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1; in_data_i = 16'hC040;
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("mrst_busy",     32'(busy_o),      32'd0);
        chk("mrst_in_ready", 32'(in_ready_o),  32'd0);
        chk("mrst_val",      32'(res_val_o),   32'd0);
        chk("mrst_idx",      32'(res_idx_o),   32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        d = '{16'h3F80, 16'h4040, 16'hC000, 16'h4000};
        push(16'h4040, 1, 1'b0);
        run(1'b0, 4, d, 1'b0);
        wait_idle();

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bf16_argmax_ctrl.md
BF16_ARGMAX_CTRL -- requirements
Module: bf16_argmax_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 256, meaning the maximum vector length in elements.
REQ-002 SHALL have localparam CNT_W = $clog2(MAX_LEN)+1, meaning the width of the length and count fields.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 start_i  input  1  begins a reduction; sampled only in IDLE.
REQ-006 mode_i  input  1  0 = argmax, 1 = argmin; latched at start.
REQ-007 len_i  input  CNT_W  vector length, 0..MAX_LEN; latched at start.
REQ-008 abort_i  input  1  synchronous cancel of the current operation.
REQ-009 in_valid_i / in_ready_o  input/output  1  element stream handshake.
REQ-010 in_data_i  input  16  bf16 element.
REQ-011 res_valid_o / res_ready_i  output/input  1  result handshake.
REQ-012 res_val_o  output  16  winning bf16 value.
REQ-013 res_idx_o  output  CNT_W  zero-based index of the winner.
REQ-014 res_nan_o  output  1  at least one NaN element was seen.
REQ-015 busy_o  output  1  state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE.
REQ-017 IDLE: start_i=1 with len_i>0 SHALL latch mode/len, clear count, best and nan flag, and go to RUN; with len_i=0 SHALL go to DONE with val 0x0000, idx 0, nan 0.
REQ-018 RUN: in_ready_o SHALL be 1; a beat is accepted when in_valid_i & in_ready_o; throughput SHALL be 1 element per cycle; gaps in in_valid_i are allowed.
REQ-019 The beat at count 0 SHALL load best := data and idx := 0 unconditionally.
REQ-020 A later beat x SHALL replace best in either of two cases: best is NaN and x is not NaN; or the single shared comparator, configured for strict less-than, returns 1 with operands (best, x) in argmax mode or (x, best) in argmin mode.
REQ-021 NaN SHALL mean exponent 0xFF with a nonzero fraction; +/-inf SHALL NOT count as NaN.
REQ-022 Ties, including +0 versus -0, SHALL keep the earlier index.
REQ-023 Any accepted NaN SHALL set the sticky nan flag.
REQ-024 Acceptance of beat count = len-1 SHALL move the block to DONE; res_valid_o SHALL rise in the next cycle, giving 1-cycle latency after the last beat.
REQ-025 DONE: in_ready_o SHALL be 0; res_* SHALL hold stable while res_valid_o & ~res_ready_i; a handshake SHALL return the block to IDLE the next cycle.
REQ-026 start_i outside IDLE SHALL be ignored.
REQ-027 A start and a result handshake in the same cycle SHALL NOT start a new run; start is only taken from IDLE.
REQ-028 abort_i SHALL force IDLE in the next cycle from any state with no result produced, and SHALL have priority over all other events.
REQ-029 in_ready_o and res_valid_o SHALL be registered-state decodes with no combinational path from in_valid_i or res_ready_i.

Reset
REQ-030 While rst_ni=0, the block SHALL be in IDLE with all outputs 0 (res_val_o 0x0000, res_idx_o 0, busy_o 0); internal registers SHALL clear to 0.
REQ-031 Reset mid-RUN or mid-DONE SHALL discard the operation.

Structure
REQ-032 A package bf16_ctrl_pkg SHALL hold the state enum, the BF16_EXP_MAX (0xFF) constant and the is_nan function.
REQ-033 The block SHALL instantiate exactly one bf16_cmp with doEq_i=0, doLt_i=1, doLe_i=0; operand order SHALL be muxed by mode.

Verification
REQ-034 Argmax, len 4, inputs 0x3F80, 0x4040, 0xC000, 0x4000 -> val 0x4040, idx 1, nan 0; res_valid_o rises 1 cycle after the 4th beat.
REQ-035 Argmin, len 3, inputs 0x0000, 0x8000, 0x3F80 -> val 0x0000, idx 0 (tie keeps first).
REQ-036 Argmax, len 3, inputs 0x7FC1, 0x3F80, 0x7F80 -> val 0x7F80, idx 2, nan 1; a second run with all-NaN input 0x7FC1, 0xFFC0 -> val 0x7FC1, idx 0, nan 1.
REQ-037 Hold res_ready_i=0 for 5 cycles and pulse start_i meanwhile -> outputs stable, in_ready_o 0, no restart; after the handshake -> IDLE.
REQ-038 len 0 start -> DONE with 0x0000/0/0; len MAX_LEN with random in_valid gaps -> idx matches the model; count reaches MAX_LEN-1 without overflow.
REQ-039 abort_i after 2 of 4 beats -> IDLE, no res_valid_o; rst_ni low mid-RUN -> all outputs 0 immediately, next run correct.
